fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the RV32I pipeline. It owns the program counter and issues one word request per cycle to the registered instruction memory (strobe/ack, one-cycle read latency). It tracks the in-flight request and presents instruction/PC pairs to the decode stage. It absorbs decode stalls with a one-entry skid buffer and discards in-flight fetches on a PC redirect from execute.

## Interface
- MEMORY_DEPTH, 8192, instruction memory depth in 32-bit words; ADDR_W = $clog2(MEMORY_DEPTH)
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- o_imem_addr  out  ADDR_W  word address to instruction memory, = pc[ADDR_W+1:2]
- o_imem_stb  out  1  fetch request, sampled by memory at the next rising edge
- i_imem_instr  in  32  instruction word from memory, valid the cycle after the strobe
- i_imem_ack  in  1  memory acknowledge, high the cycle after an accepted strobe
- i_stall  in  1  decode cannot accept; the output must hold
- i_change_pc  in  1  redirect (taken branch/jump) from execute
- i_new_pc  in  32  redirect target byte address; bits [1:0] ignored (forced 0)
- o_instr  out  32  instruction to decode
- o_pc  out  32  byte address of o_instr
- o_valid  out  1  o_instr/o_pc hold a live instruction

## Operation
- Registers: pc (next fetch address), run, inflight_valid, inflight_pc, skid_valid, skid_instr, skid_pc, output regs.
- Reset (i_rst_n=0, async): pc=RESET_PC, run=0, inflight_valid=0, skid_valid=0, o_valid=0, o_instr=0, o_pc=0. Because o_imem_stb is gated by run, it is 0 during reset.
- run goes to 1 on the first clock edge after reset deasserts and stays 1.
- o_imem_stb = run & ~i_stall & ~i_change_pc. This is combinational from registers and inputs.
- On an edge where stb=1: inflight_valid<=1, inflight_pc<=pc, pc<=pc+4. The add is 32-bit and wraps mod 2^32; the word address wraps mod MEMORY_DEPTH.
- On an edge where stb=0: inflight_valid<=0.
- An incoming response is accepted only if i_imem_ack & inflight_valid. Any other ack is discarded, whether stale from reset or killed by a redirect.
- Redirect (i_change_pc=1) has highest priority, over stall:
  - pc<=i_new_pc & ~3
  - inflight_valid<=0
  - skid_valid<=0
  - o_valid<=0
  - no strobe that cycle
  - the ack returning next cycle is discarded
- Not stalled (i_stall=0, no redirect):
  - If skid_valid: the output loads from the skid and skid_valid<=0.
  - Else if a response is accepted: the output loads {i_imem_instr, inflight_pc} with o_valid<=1.
  - Else o_valid<=0.
- Stalled (i_stall=1, no redirect):
  - The output holds all fields, including o_valid.
  - An accepted response loads the skid (skid_valid<=1).
  - The skid cannot already be full, because no strobe is issued while stalled, so at most one request is in flight.
- Skid and a new response never coincide. When stall drops, the skid drains that cycle and the strobe issued that same cycle returns one cycle later.

## Timing
- Strobe at cycle N → ack/instr at N+1 → o_valid with that instruction at N+2. Fetch latency is 2 cycles.
- Throughput is 1 instruction/cycle with no stalls or redirects.
- Reset release: first strobe in the cycle after run sets; first o_valid 2 cycles later.
- Stall asserted at cycle S: the strobe issued at S-1 returns at S into the skid; no strobes during S..end of stall.
- Stall released at cycle U: the skid is presented at U+1, the strobe issues at U, and its data is presented at U+2. There is no bubble and no duplicate.
- Redirect at cycle R: o_valid=0 at R+1, strobe to the new pc at R+1, first target instruction valid at R+3.
- Redirect and stall in the same cycle: the redirect wins; the output is invalidated despite the stall.
- Reset asserted mid-operation clears all state immediately; in-flight data is dropped.

## Test plan
- Reset release, RESET_PC=0, memory words k at address k:
  - Strobes must appear with addr 0,1,2,…
  - o_valid rises 3 cycles after reset release with o_pc=0, o_instr=word 0.
  - Then o_pc increments by 4 every cycle.
- Stall high for 3 cycles while streaming at o_pc=0x10:
  - o_pc holds 0x10 for those cycles.
  - After release, the sequence continues with 0x14, 0x18 with no gap, skip or duplicate.
- Single-cycle stall:
  - The skid fills and drains.
  - The output sequence is still strictly +4 with exactly one repeated cycle.
- i_change_pc with i_new_pc=0x103 while streaming:
  - o_valid=0 for 2 cycles.
  - Then o_pc=0x100, 0x104, …
  - The in-flight old instruction never appears.
- Redirect asserted together with i_stall=1 and the skid full:
  - The skid is discarded.
  - The first valid output is the target instruction.
- Wrap: MEMORY_DEPTH=16, RESET_PC=0x38:
  - o_imem_addr sequence is 14, 15, 0, 1.
  - o_pc runs 0x38, 0x3C, 0x40, 0x44 (byte PC does not wrap at depth).

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the RV32I pipeline. Owns the program counter,
// issues one word request per cycle to a registered instruction memory
// (strobe/ack, one-cycle read latency), tracks the single in-flight request,
// absorbs decode stalls with a one-entry skid buffer and discards in-flight
// fetches on a redirect from execute.
//
// Ports
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   o_imem_addr         word address to instruction memory (pc[ADDR_W+1:2])
//   o_imem_stb          fetch request, combinational from run/stall/redirect
//   i_imem_instr        instruction word, valid the cycle after the strobe
//   i_imem_ack          memory acknowledge, the cycle after the strobe
//   i_stall             decode cannot accept; outputs hold
//   i_change_pc         redirect from execute (wins over stall)
//   i_new_pc            redirect target byte address, bits [1:0] ignored
//   o_instr, o_pc       instruction/PC pair presented to decode
//   o_valid             o_instr/o_pc hold a live instruction
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int unsigned  MEMORY_DEPTH = 8192,
  parameter logic [31:0]  RESET_PC     = 32'h0000_0000,
  localparam int unsigned ADDR_W       = $clog2(MEMORY_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic              o_imem_stb,
  input  logic [31:0]       i_imem_instr,
  input  logic              i_imem_ack,
  input  logic              i_stall,
  input  logic              i_change_pc,
  input  logic [31:0]       i_new_pc,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  output logic              o_valid
);

  logic        run;
  logic [31:0] pc;
  logic        inflight_valid;
  logic [31:0] inflight_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        accept;

  // No request while stalled or redirecting, so at most one fetch is in flight.
  assign o_imem_stb  = run & ~i_stall & ~i_change_pc;
  assign o_imem_addr = pc[ADDR_W+1:2];

  // Acks that do not belong to a live request (post-reset or killed) are dropped.
  assign accept = i_imem_ack & inflight_valid;

  // Program counter, run flag and in-flight request tracking.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      run            <= 1'b0;
      pc             <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= '0;
    end else begin
      run            <= 1'b1;
      inflight_valid <= o_imem_stb;
      if (i_change_pc) begin
        pc <= i_new_pc & 32'hFFFF_FFFC;
      end else if (o_imem_stb) begin
        inflight_pc <= pc;
        pc          <= pc + 32'd4;
      end
    end
  end

  // Skid buffer and decode-facing output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      o_valid    <= 1'b0;
      o_instr    <= '0;
      o_pc       <= '0;
    end else if (i_change_pc) begin
      skid_valid <= 1'b0;
      o_valid    <= 1'b0;
    end else if (!i_stall) begin
      if (skid_valid) begin
        // Skid drains first; no response can arrive this cycle since
        // nothing was strobed during the stall.
        o_instr    <= skid_instr;
        o_pc       <= skid_pc;
        o_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else if (accept) begin
        o_instr <= i_imem_instr;
        o_pc    <= inflight_pc;
        o_valid <= 1'b1;
      end else begin
        o_valid <= 1'b0;
      end
    end else if (accept) begin
      // Stalled: outputs hold, the response that was already in flight parks here.
      skid_instr <= i_imem_instr;
      skid_pc    <= inflight_pc;
      skid_valid <= 1'b1;
    end
  end

endmodule
